cache_op1_out: RTL and testbench



---
 rtl/cache_pkg.sv | 19 +
 rtl/axis_out_reg.sv | 45 ++++
 rtl/cache_op1_out.sv | 127 ++++++++++++
 tb/tb_cache_op1_out.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache op egress blocks: state encoding,
// counter widths and default stream widths.
package cache_pkg;

  localparam int unsigned DEF_DATA_W  = 256;
  localparam int unsigned DEF_TUSER_W = 128;

  localparam int unsigned PKT_CNT_W   = 32;
  localparam int unsigned BEAT_CNT_W  = 32;
  localparam int unsigned TRUNC_CNT_W = 16;

  // Egress framing state; encodings are fixed for status readback.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_STREAM  = 2'b01,
    ST_DISCARD = 2'b10
  } op_state_t;

endpackage

// File: rtl/axis_out_reg.sv
// One-entry AXI4-Stream output register. A load captures a new beat and
// raises tvalid; the beat is held stable until tready. slot_free tells the
// producer a load may happen this cycle.
module axis_out_reg #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned USER_W = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [DATA_W-1:0]   in_tdata,
  input  logic [DATA_W/8-1:0] in_tkeep,
  input  logic [USER_W-1:0]   in_tuser,
  input  logic                in_tlast,
  input  logic                tready,
  output logic [DATA_W-1:0]   tdata,
  output logic [DATA_W/8-1:0] tkeep,
  output logic [USER_W-1:0]   tuser,
  output logic                tlast,
  output logic                tvalid,
  output logic                slot_free
);

  assign slot_free = !tvalid || tready;

  // Capture on load, otherwise hold the beat until it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdata  <= '0;
      tkeep  <= '0;
      tuser  <= '0;
      tlast  <= 1'b0;
      tvalid <= 1'b0;
    end else if (load) begin
      tdata  <= in_tdata;
      tkeep  <= in_tkeep;
      tuser  <= in_tuser;
      tlast  <= in_tlast;
      tvalid <= 1'b1;
    end else if (tready) begin
      tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/cache_op1_out.sv
// op1 cache egress: drains the fallthrough packet FIFO into a 256-bit
// AXI4-Stream master with start gating, a maximum-length guard that forces
// tlast, discard of over-length remainders, and status counters.
module cache_op1_out
  import cache_pkg::*;
#(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = DEF_DATA_W,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = DEF_TUSER_W,
  parameter int unsigned MAX_BEATS            = 64
) (
  input  logic                              axis_aclk,
  input  logic                              axis_resetn,
  input  logic                              i_pkt_fifo_empty,
  output logic                              o_pkt_fifo_rd_en,
  input  logic [C_M_AXIS_DATA_WIDTH-1:0]    i_tdata_fifo,
  input  logic [C_M_AXIS_TUSER_WIDTH-1:0]   i_tuser_fifo,
  input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]  i_tkeep_fifo,
  input  logic                              i_tlast_fifo,
  input  logic                              i_enable,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    o_cache_m_axis_op1_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  o_cache_m_axis_op1_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   o_cache_m_axis_op1_tuser,
  output logic                              o_cache_m_axis_op1_tvalid,
  output logic                              o_cache_m_axis_op1_tlast,
  input  logic                              i_cache_m_axis_op1_tready,
  output logic [PKT_CNT_W-1:0]              o_pkt_cnt,
  output logic [BEAT_CNT_W-1:0]             o_beat_cnt,
  output logic [TRUNC_CNT_W-1:0]            o_trunc_cnt,
  output logic                              o_busy
);

  localparam int unsigned BEAT_IDX_W = $clog2(MAX_BEATS + 1);
  localparam logic [BEAT_IDX_W-1:0] LAST_IDX = BEAT_IDX_W'(MAX_BEATS - 1);

  op_state_t             state;
  logic [BEAT_IDX_W-1:0] beat_idx;

  logic fifo_ok;
  logic discard_pop;
  logic slot_free;
  logic load;
  logic trunc_load;
  logic out_last;
  logic handshake;

  // Decide whether the head FIFO word is loaded, discarded or left alone.
  always_comb begin
    fifo_ok     = 1'b0;
    discard_pop = 1'b0;
    case (state)
      ST_IDLE:    fifo_ok     = !i_pkt_fifo_empty && i_enable;
      ST_STREAM:  fifo_ok     = !i_pkt_fifo_empty;
      ST_DISCARD: discard_pop = !i_pkt_fifo_empty;
      default:    ;
    endcase
    load       = slot_free && fifo_ok;
    trunc_load = load && (state == ST_STREAM) && (beat_idx == LAST_IDX) && !i_tlast_fifo;
    out_last   = i_tlast_fifo || trunc_load;
    // Never pop while reset is held, even though the FIFO may look non-empty.
    o_pkt_fifo_rd_en = axis_resetn && (load || discard_pop);
  end

  assign handshake = o_cache_m_axis_op1_tvalid && i_cache_m_axis_op1_tready;
  assign o_busy    = (state != ST_IDLE) || o_cache_m_axis_op1_tvalid;

  axis_out_reg #(
    .DATA_W (C_M_AXIS_DATA_WIDTH),
    .USER_W (C_M_AXIS_TUSER_WIDTH)
  ) u_out_reg (
    .clk       (axis_aclk),
    .rst_n     (axis_resetn),
    .load      (load),
    .in_tdata  (i_tdata_fifo),
    .in_tkeep  (i_tkeep_fifo),
    .in_tuser  (i_tuser_fifo),
    .in_tlast  (out_last),
    .tready    (i_cache_m_axis_op1_tready),
    .tdata     (o_cache_m_axis_op1_tdata),
    .tkeep     (o_cache_m_axis_op1_tkeep),
    .tuser     (o_cache_m_axis_op1_tuser),
    .tlast     (o_cache_m_axis_op1_tlast),
    .tvalid    (o_cache_m_axis_op1_tvalid),
    .slot_free (slot_free)
  );

  // Packet framing: track beats loaded and route over-length tails to DISCARD.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state    <= ST_IDLE;
      beat_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            beat_idx <= BEAT_IDX_W'(1);
            if (!i_tlast_fifo) state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (load) begin
            beat_idx <= beat_idx + 1'b1;
            if (i_tlast_fifo)            state <= ST_IDLE;
            else if (beat_idx == LAST_IDX) state <= ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (!i_pkt_fifo_empty && i_tlast_fifo) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Status counters: beats and packets on handshakes, truncations at the load.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      o_pkt_cnt   <= '0;
      o_beat_cnt  <= '0;
      o_trunc_cnt <= '0;
    end else begin
      if (handshake)                            o_beat_cnt  <= o_beat_cnt + 1'b1;
      if (handshake && o_cache_m_axis_op1_tlast) o_pkt_cnt   <= o_pkt_cnt + 1'b1;
      if (trunc_load)                           o_trunc_cnt <= o_trunc_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_op1_out.sv
// Scoreboard bench for cache_op1_out (MAX_BEATS=4). The bench models the
// fallthrough FIFO; tests push FIFO words and the hand-derived expected
// stream beats, and a monitor pops/compares on every stream handshake.
module tb_cache_op1_out;

  localparam int unsigned DW = 256;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned UW = 128;

  typedef struct {
    logic [31:0] tag;
    logic        last;
  } word_t;

  logic          clk;
  logic          rst_n;
  logic          empty;
  logic          rd_en;
  logic [DW-1:0] f_tdata;
  logic [UW-1:0] f_tuser;
  logic [KW-1:0] f_tkeep;
  logic          f_tlast;
  logic          enable;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic [UW-1:0] tuser;
  logic          tvalid;
  logic          tlast;
  logic          tready;
  logic [31:0]   pkt_cnt;
  logic [31:0]   beat_cnt;
  logic [15:0]   trunc_cnt;
  logic          busy;

  word_t fifo_q[$];
  word_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    pops     = 0;

  cache_op1_out #(
    .C_M_AXIS_DATA_WIDTH  (DW),
    .C_M_AXIS_TUSER_WIDTH (UW),
    .MAX_BEATS            (4)
  ) dut (
    .axis_aclk                 (clk),
    .axis_resetn               (rst_n),
    .i_pkt_fifo_empty          (empty),
    .o_pkt_fifo_rd_en          (rd_en),
    .i_tdata_fifo              (f_tdata),
    .i_tuser_fifo              (f_tuser),
    .i_tkeep_fifo              (f_tkeep),
    .i_tlast_fifo              (f_tlast),
    .i_enable                  (enable),
    .o_cache_m_axis_op1_tdata  (tdata),
    .o_cache_m_axis_op1_tkeep  (tkeep),
    .o_cache_m_axis_op1_tuser  (tuser),
    .o_cache_m_axis_op1_tvalid (tvalid),
    .o_cache_m_axis_op1_tlast  (tlast),
    .i_cache_m_axis_op1_tready (tready),
    .o_pkt_cnt                 (pkt_cnt),
    .o_beat_cnt                (beat_cnt),
    .o_trunc_cnt               (trunc_cnt),
    .o_busy                    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk_data(logic [31:0] tag);
    return {8{tag}};
  endfunction
  function automatic logic [KW-1:0] mk_keep(logic [31:0] tag);
    return tag ^ 32'hFFFF_0000;
  endfunction
  function automatic logic [UW-1:0] mk_user(logic [31:0] tag);
    return {4{~tag}};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present the FIFO head on the fallthrough read interface.
  task automatic drive();
    empty = (fifo_q.size() == 0);
    if (fifo_q.size() > 0) begin
      f_tdata = mk_data(fifo_q[0].tag);
      f_tkeep = mk_keep(fifo_q[0].tag);
      f_tuser = mk_user(fifo_q[0].tag);
      f_tlast = fifo_q[0].last;
    end else begin
      f_tdata = '0;
      f_tkeep = '0;
      f_tuser = '0;
      f_tlast = 1'b0;
    end
  endtask

  task automatic push_word(logic [31:0] tag, logic last);
    word_t w;
    w.tag = tag;
    w.last = last;
    fifo_q.push_back(w);
    drive();
  endtask

  task automatic expect_beat(logic [31:0] tag, logic last);
    word_t w;
    w.tag = tag;
    w.last = last;
    exp_q.push_back(w);
  endtask

  // One clock: rd_en sampled before the edge, FIFO popped just after it.
  task automatic tick();
    logic popped;
    @(negedge clk);
    popped = rd_en;
    @(posedge clk);
    #1;
    if (popped) begin
      if (fifo_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_empty: got rd_en=1 expected rd_en=0 with FIFO empty");
      end else begin
        void'(fifo_q.pop_front());
        pops++;
      end
    end
    drive();
  endtask

  task automatic drain(string name);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    while (!done && n < 200) begin
      tick();
      n++;
      done = (exp_q.size() == 0) && (fifo_q.size() == 0) && !tvalid;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_drain: got %0d beats outstanding expected 0", name, exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    pops = 0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compare every handshaken beat against the scoreboard head.
  initial begin
    word_t e;
    forever begin
      @(negedge clk);
      if (rst_n && tvalid && tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL beat_unexpected: got tag %0h expected no beat", tdata[31:0]);
        end else begin
          e = exp_q.pop_front();
          if (tdata !== mk_data(e.tag) || tkeep !== mk_keep(e.tag) ||
              tuser !== mk_user(e.tag) || tlast !== e.last) begin
            failures++;
            $display("FAIL beat: got tag %0h last %0b expected tag %0h last %0b",
                     tdata[31:0], tlast, e.tag, e.last);
          end
        end
      end
    end
  end

  initial begin
    int pat[5];
    rst_n  = 1'b0;
    enable = 1'b1;
    tready = 1'b1;
    drive();

    // Reset state
    #3;
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_rd_en", 64'(rd_en), 64'd0);
    check("rst_cnts", {pkt_cnt, beat_cnt} | 64'(trunc_cnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    // 1: 3-beat packet at full rate
    do_reset();
    push_word(32'hA001, 0); expect_beat(32'hA001, 0);
    push_word(32'hA002, 0); expect_beat(32'hA002, 0);
    push_word(32'hA003, 1); expect_beat(32'hA003, 1);
    repeat (3) tick();
    check("t1_beats_after3", 64'(beat_cnt), 64'd2);
    tick();
    check("t1_beats_after4", 64'(beat_cnt), 64'd3);
    check("t1_pkts", 64'(pkt_cnt), 64'd1);
    check("t1_pops", 64'(pops), 64'd3);
    drain("t1");

    // 2: tready pattern 1,0,0,1,1
    do_reset();
    push_word(32'hB001, 0); expect_beat(32'hB001, 0);
    push_word(32'hB002, 0); expect_beat(32'hB002, 0);
    push_word(32'hB003, 1); expect_beat(32'hB003, 1);
    pat = '{1, 0, 0, 1, 1};
    for (int i = 0; i < 5; i++) begin
      tready = pat[i][0];
      #1;
      if (tvalid && !tready) begin
        check("t2_stall_rd_en", 64'(rd_en), 64'd0);
        check("t2_stall_data", tdata[63:0], mk_data(exp_q[0].tag) >> 0 & 64'hFFFF_FFFF_FFFF_FFFF);
      end
      tick();
    end
    tready = 1'b1;
    drain("t2");
    check("t2_beats", 64'(beat_cnt), 64'd3);
    check("t2_pkts", 64'(pkt_cnt), 64'd1);

    // 3: 6-beat packet truncated at 4, then a 2-beat packet
    do_reset();
    for (int i = 1; i <= 6; i++) push_word(32'hC000 + 32'(i), (i == 6));
    push_word(32'hD001, 0);
    push_word(32'hD002, 1);
    expect_beat(32'hC001, 0);
    expect_beat(32'hC002, 0);
    expect_beat(32'hC003, 0);
    expect_beat(32'hC004, 1);
    expect_beat(32'hD001, 0);
    expect_beat(32'hD002, 1);
    drain("t3");
    check("t3_trunc", 64'(trunc_cnt), 64'd1);
    check("t3_pkts", 64'(pkt_cnt), 64'd2);
    check("t3_beats", 64'(beat_cnt), 64'd6);
    check("t3_pops", 64'(pops), 64'd8);

    // 4: enable gating, and enable dropped during beat 2
    do_reset();
    enable = 1'b0;
    for (int i = 1; i <= 4; i++) push_word(32'hE000 + 32'(i), (i == 4));
    push_word(32'hF001, 0);
    push_word(32'hF002, 1);
    repeat (3) tick();
    check("t4_gated_rd_en", 64'(rd_en), 64'd0);
    check("t4_gated_tvalid", 64'(tvalid), 64'd0);
    for (int i = 1; i <= 4; i++) expect_beat(32'hE000 + 32'(i), (i == 4));
    enable = 1'b1;
    tick();
    tick();
    enable = 1'b0;
    repeat (10) tick();
    check("t4_pops", 64'(pops), 64'd4);
    check("t4_held", 64'(fifo_q.size()), 64'd2);
    check("t4_pkts", 64'(pkt_cnt), 64'd1);
    check("t4_idle_tvalid", 64'(tvalid), 64'd0);
    expect_beat(32'hF001, 0);
    expect_beat(32'hF002, 1);
    enable = 1'b1;
    drain("t4");
    check("t4_pkts_final", 64'(pkt_cnt), 64'd2);

    // 5: FIFO empty for 5 cycles between beats 2 and 3
    do_reset();
    push_word(32'h6001, 0); expect_beat(32'h6001, 0);
    push_word(32'h6002, 0); expect_beat(32'h6002, 0);
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      check("t5_gap_tvalid", 64'(tvalid), 64'd0);
      check("t5_gap_busy", 64'(busy), 64'd1);
      tick();
    end
    push_word(32'h6003, 1); expect_beat(32'h6003, 1);
    drain("t5");
    check("t5_beats", 64'(beat_cnt), 64'd3);
    check("t5_pkts", 64'(pkt_cnt), 64'd1);

    // 6: tlast exactly on beat 4, then a single-beat packet
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      push_word(32'h7000 + 32'(i), (i == 4));
      expect_beat(32'h7000 + 32'(i), (i == 4));
    end
    push_word(32'h8001, 1); expect_beat(32'h8001, 1);
    drain("t6");
    check("t6_trunc", 64'(trunc_cnt), 64'd0);
    check("t6_pkts", 64'(pkt_cnt), 64'd2);

    // 7: reset while beat 2 is presented
    do_reset();
    tready = 1'b0;
    for (int i = 1; i <= 4; i++) push_word(32'h9000 + 32'(i), (i == 4));
    expect_beat(32'h9001, 0);
    tick();
    tready = 1'b1;
    tick();
    tready = 1'b0;
    tick();
    check("t7_pre_tvalid", 64'(tvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t7_rst_tvalid", 64'(tvalid), 64'd0);
    check("t7_rst_cnts", {pkt_cnt, beat_cnt}, 64'd0);
    check("t7_rst_rd_en", 64'(rd_en), 64'd0);
    check("t7_fifo_left", 64'(fifo_q.size()), 64'd2);
    exp_q.delete();
    expect_beat(32'h9003, 0);
    expect_beat(32'h9004, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tready = 1'b1;
    drain("t7");
    check("t7_pkts", 64'(pkt_cnt), 64'd1);
    check("t7_beats", 64'(beat_cnt), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
